// File: rtl/level_pkg.sv
// Shared types and constants for the game-level sequencer.
package level_pkg;

    localparam int unsigned SCORE_W_DEF = 16;
    localparam int unsigned GOAL_LEVELS = 4;

    typedef enum logic [2:0] {
        TITLE,
        START,
        PLAY,
        WAIT_END,
        LEVEL_WIN,
        GAME_OVER,
        GAME_WON
    } state_e;

    localparam int unsigned GOAL [GOAL_LEVELS] = '{50, 120, 200, 300};

    // Levels beyond the table reuse the last goal.
    function automatic int unsigned goal_for(input logic [2:0] lvl);
        int unsigned idx;
        idx = 32'(lvl);
        if (idx >= GOAL_LEVELS) begin
            idx = GOAL_LEVELS - 1;
        end
        return GOAL[idx];
    endfunction

endpackage

// File: rtl/level_timer.sv
// Per-level countdown: frame divider feeding a seconds counter that stops at zero.
module level_timer #(
    parameter int unsigned FRAMES_PER_SEC = 30,
    parameter int unsigned LEVEL_TIME_SEC = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load_i,
    input  logic       enable_i,
    input  logic       startOfFrame_i,
    output logic [6:0] seconds_left_o,
    output logic       expired_o
);

    localparam int unsigned FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [6:0]      seconds_q, seconds_d;
    logic            sec_tick;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        seconds_d   = seconds_q;
        expired_o   = 1'b0;
        sec_tick    = enable_i && startOfFrame_i && (frame_cnt_q == FC_W'(FRAMES_PER_SEC - 1));
        if (load_i) begin
            frame_cnt_d = '0;
            seconds_d   = 7'(LEVEL_TIME_SEC);
        end else if (enable_i && startOfFrame_i) begin
            if (sec_tick) begin
                frame_cnt_d = '0;
                if (seconds_q != '0) begin
                    seconds_d = seconds_q - 7'd1;
                    // Pulses on the same cycle seconds_left reaches zero.
                    expired_o = (seconds_q == 7'd1);
                end
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q <= '0;
            seconds_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            seconds_q   <= seconds_d;
        end
    end

    assign seconds_left_o = seconds_q;

endmodule

// File: rtl/level_manager.sv
// Game-level sequencer: level start, countdown, score accumulation, win/lose and screen selects.
module level_manager
    import level_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC = 30,
    parameter int unsigned LEVEL_TIME_SEC = 60,
    parameter int unsigned NUM_LEVELS     = 4,
    parameter int unsigned SCORE_W        = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               is_enter_pressed,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               level_ended,
    output logic               start_level,
    output logic               timer_endedN,
    output logic [6:0]         seconds_left,
    output logic [SCORE_W-1:0] goal,
    output logic [2:0]         level_num,
    output logic [SCORE_W-1:0] level_score,
    output logic [SCORE_W-1:0] total_score,
    output logic               show_title,
    output logic               show_level_win,
    output logic               show_game_over,
    output logic               show_game_won
);

    state_e             state_q, state_d;
    logic [2:0]         level_num_q, level_num_d;
    logic [SCORE_W-1:0] level_score_q, level_score_d;
    logic [SCORE_W-1:0] total_score_q, total_score_d;
    logic [SCORE_W-1:0] goal_q;
    logic               timer_endedN_q, timer_endedN_d;
    logic               enter_prev_q;
    logic               enter_edge;
    logic               enter_start;
    logic               accumulate;
    logic               timer_expired;
    logic [SCORE_W-1:0] level_sum, total_sum;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    assign enter_edge = is_enter_pressed & ~enter_prev_q;
    assign accumulate = (state_q == PLAY) || (state_q == WAIT_END);
    assign level_sum  = sat_add(level_score_q, score_in);
    assign total_sum  = sat_add(total_score_q, score_in);

    level_timer #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC),
        .LEVEL_TIME_SEC(LEVEL_TIME_SEC)
    ) u_timer (
        .clk            (clk),
        .resetN         (resetN),
        .load_i         (enter_start),
        .enable_i       (state_q == PLAY),
        .startOfFrame_i (startOfFrame),
        .seconds_left_o (seconds_left),
        .expired_o      (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        level_num_d    = level_num_q;
        level_score_d  = level_score_q;
        total_score_d  = total_score_q;
        timer_endedN_d = timer_endedN_q;
        enter_start    = 1'b0;

        case (state_q)
            TITLE: begin
                if (enter_edge) begin
                    state_d       = START;
                    total_score_d = '0;
                    level_num_d   = '0;
                    enter_start   = 1'b1;
                end
            end
            START: state_d = PLAY;
            PLAY: begin
                if (timer_expired) begin
                    timer_endedN_d = 1'b0;
                    state_d        = WAIT_END;
                end
            end
            WAIT_END: begin
                // Compare against the sum including this cycle's points.
                if (level_ended) begin
                    if (level_sum >= goal_q) begin
                        state_d = (level_num_q == 3'(NUM_LEVELS - 1)) ? GAME_WON : LEVEL_WIN;
                    end else begin
                        state_d = GAME_OVER;
                    end
                end
            end
            LEVEL_WIN: begin
                if (enter_edge) begin
                    state_d     = START;
                    level_num_d = level_num_q + 3'd1;
                    enter_start = 1'b1;
                end
            end
            GAME_OVER, GAME_WON: begin
                if (enter_edge) begin
                    state_d = TITLE;
                end
            end
            default: state_d = TITLE;
        endcase

        if (accumulate) begin
            level_score_d = level_sum;
            total_score_d = total_sum;
        end
        if (enter_start) begin
            level_score_d  = '0;
            timer_endedN_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= TITLE;
            level_num_q    <= '0;
            level_score_q  <= '0;
            total_score_q  <= '0;
            goal_q         <= SCORE_W'(goal_for(3'd0));
            timer_endedN_q <= 1'b1;
            enter_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_num_q    <= level_num_d;
            level_score_q  <= level_score_d;
            total_score_q  <= total_score_d;
            goal_q         <= SCORE_W'(goal_for(level_num_q));
            timer_endedN_q <= timer_endedN_d;
            enter_prev_q   <= is_enter_pressed;
        end
    end

    assign start_level    = (state_q == START);
    assign timer_endedN   = timer_endedN_q;
    assign goal           = goal_q;
    assign level_num      = level_num_q;
    assign level_score    = level_score_q;
    assign total_score    = total_score_q;
    assign show_title     = (state_q == TITLE);
    assign show_level_win = (state_q == LEVEL_WIN);
    assign show_game_over = (state_q == GAME_OVER);
    assign show_game_won  = (state_q == GAME_WON);

endmodule

// File: tb/tb_level_manager.sv
// Directed bench for level_manager: main 16-bit instance plus an 8-bit instance for saturation.
module tb_level_manager;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance (SCORE_W = 16)
    logic        resetN = 1'b0, sof = 1'b0, enter = 1'b0, lvl_end = 1'b0;
    logic [15:0] score_in = '0;
    logic        start_level, timer_endedN;
    logic [6:0]  seconds_left;
    logic [15:0] goal, level_score, total_score;
    logic [2:0]  level_num;
    logic        show_title, show_level_win, show_game_over, show_game_won;

    level_manager #(
        .FRAMES_PER_SEC(2),
        .LEVEL_TIME_SEC(3),
        .NUM_LEVELS    (4),
        .SCORE_W       (16)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (sof),
        .is_enter_pressed(enter),
        .score_in        (score_in),
        .level_ended     (lvl_end),
        .start_level     (start_level),
        .timer_endedN    (timer_endedN),
        .seconds_left    (seconds_left),
        .goal            (goal),
        .level_num       (level_num),
        .level_score     (level_score),
        .total_score     (total_score),
        .show_title      (show_title),
        .show_level_win  (show_level_win),
        .show_game_over  (show_game_over),
        .show_game_won   (show_game_won)
    );

    // Saturation instance (SCORE_W = 8)
    logic       resetN2 = 1'b0, sof2 = 1'b0, enter2 = 1'b0, lvl_end2 = 1'b0;
    logic [7:0] score_in2 = '0;
    logic       start_level2, timer_endedN2;
    logic [6:0] seconds_left2;
    logic [7:0] goal2, level_score2, total_score2;
    logic [2:0] level_num2;
    logic       show_title2, show_level_win2, show_game_over2, show_game_won2;

    level_manager #(
        .FRAMES_PER_SEC(2),
        .LEVEL_TIME_SEC(3),
        .NUM_LEVELS    (4),
        .SCORE_W       (8)
    ) dut8 (
        .clk             (clk),
        .resetN          (resetN2),
        .startOfFrame    (sof2),
        .is_enter_pressed(enter2),
        .score_in        (score_in2),
        .level_ended     (lvl_end2),
        .start_level     (start_level2),
        .timer_endedN    (timer_endedN2),
        .seconds_left    (seconds_left2),
        .goal            (goal2),
        .level_num       (level_num2),
        .level_score     (level_score2),
        .total_score     (total_score2),
        .show_title      (show_title2),
        .show_level_win  (show_level_win2),
        .show_game_over  (show_game_over2),
        .show_game_won   (show_game_won2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        tick(2);
        checks++; if (show_title !== 1'b1) begin failures++; $display("FAIL rst_title got=%0b exp=1", show_title); end
        checks++; if ({show_level_win, show_game_over, show_game_won} !== 3'b000) begin failures++; $display("FAIL rst_shows got=%b exp=000", {show_level_win, show_game_over, show_game_won}); end
        checks++; if (start_level !== 1'b0) begin failures++; $display("FAIL rst_start got=%0b exp=0", start_level); end
        checks++; if (timer_endedN !== 1'b1) begin failures++; $display("FAIL rst_timerN got=%0b exp=1", timer_endedN); end
        checks++; if (seconds_left !== 7'd0) begin failures++; $display("FAIL rst_secs got=%0d exp=0", seconds_left); end
        checks++; if (goal !== 16'd50) begin failures++; $display("FAIL rst_goal got=%0d exp=50", goal); end
        checks++; if ({level_num, level_score, total_score} !== 35'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", level_num, level_score, total_score); end
        resetN = 1'b1;
        tick(1);
        checks++; if (show_title !== 1'b1) begin failures++; $display("FAIL idle_title got=%0b exp=1", show_title); end
    endtask

    task automatic test_start;
        enter = 1'b1;
        tick(1);
        checks++; if (start_level !== 1'b1) begin failures++; $display("FAIL start_pulse got=%0b exp=1", start_level); end
        checks++; if (seconds_left !== 7'd3) begin failures++; $display("FAIL start_secs got=%0d exp=3", seconds_left); end
        checks++; if (timer_endedN !== 1'b1) begin failures++; $display("FAIL start_timerN got=%0b exp=1", timer_endedN); end
        checks++; if (goal !== 16'd50) begin failures++; $display("FAIL start_goal got=%0d exp=50", goal); end
        tick(1);
        checks++; if (start_level !== 1'b0) begin failures++; $display("FAIL start_one_cycle got=%0b exp=0", start_level); end
        checks++; if (show_title !== 1'b0) begin failures++; $display("FAIL play_title got=%0b exp=0", show_title); end
        enter = 1'b0;
    endtask

    task automatic test_countdown;
        for (int k = 1; k <= 6; k++) begin
            sof = 1'b1;
            tick(1);
            sof = 1'b0;
            checks++; if (seconds_left !== 7'(3 - k / 2)) begin failures++; $display("FAIL cd_secs pulse=%0d got=%0d exp=%0d", k, seconds_left, 3 - k / 2); end
            checks++; if (timer_endedN !== (k < 6)) begin failures++; $display("FAIL cd_timerN pulse=%0d got=%0b exp=%0b", k, timer_endedN, k < 6); end
            tick(1);
        end
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
        checks++; if (seconds_left !== 7'd0) begin failures++; $display("FAIL cd_floor got=%0d exp=0", seconds_left); end
        checks++; if (timer_endedN !== 1'b0) begin failures++; $display("FAIL cd_hold_low got=%0b exp=0", timer_endedN); end
    endtask

    task automatic test_level_win;
        score_in = 16'd30; tick(1);
        score_in = 16'd30; tick(1);
        score_in = 16'd0;
        checks++; if (level_score !== 16'd60) begin failures++; $display("FAIL win_lscore got=%0d exp=60", level_score); end
        enter = 1'b1;
        tick(1);
        lvl_end = 1'b1;
        tick(1);
        lvl_end = 1'b0;
        checks++; if (show_level_win !== 1'b1) begin failures++; $display("FAIL win_screen got=%0b exp=1", show_level_win); end
        tick(3);
        checks++; if (show_level_win !== 1'b1) begin failures++; $display("FAIL win_held_enter got=%0b exp=1", show_level_win); end
        score_in = 16'd5;
        tick(1);
        score_in = 16'd0;
        checks++; if ({level_score, total_score} !== {16'd60, 16'd60}) begin failures++; $display("FAIL win_ignore_score got=%0d/%0d exp=60/60", level_score, total_score); end
        enter = 1'b0;
        tick(1);
        enter = 1'b1;
        tick(1);
        checks++; if (start_level !== 1'b1) begin failures++; $display("FAIL l1_start got=%0b exp=1", start_level); end
        checks++; if (level_num !== 3'd1) begin failures++; $display("FAIL l1_num got=%0d exp=1", level_num); end
        checks++; if ({level_score, total_score} !== {16'd0, 16'd60}) begin failures++; $display("FAIL l1_scores got=%0d/%0d exp=0/60", level_score, total_score); end
        tick(1);
        enter = 1'b0;
        checks++; if (goal !== 16'd120) begin failures++; $display("FAIL l1_goal got=%0d exp=120", goal); end
    endtask

    task automatic test_game_over;
        for (int k = 1; k <= 6; k++) begin
            sof = 1'b1;
            if (k == 6) score_in = 16'd7;
            tick(1);
            sof = 1'b0;
            score_in = 16'd0;
            tick(1);
        end
        checks++; if (level_score !== 16'd7) begin failures++; $display("FAIL exp_cycle_score got=%0d exp=7", level_score); end
        checks++; if (timer_endedN !== 1'b0) begin failures++; $display("FAIL l1_timerN got=%0b exp=0", timer_endedN); end
        score_in = 16'd100;
        lvl_end  = 1'b1;
        tick(1);
        score_in = 16'd0;
        lvl_end  = 1'b0;
        checks++; if (level_score !== 16'd107) begin failures++; $display("FAIL over_lscore got=%0d exp=107", level_score); end
        checks++; if (total_score !== 16'd167) begin failures++; $display("FAIL over_tscore got=%0d exp=167", total_score); end
        checks++; if (show_game_over !== 1'b1) begin failures++; $display("FAIL over_screen got=%0b exp=1", show_game_over); end
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
        checks++; if (show_title !== 1'b1) begin failures++; $display("FAIL over_title got=%0b exp=1", show_title); end
        checks++; if (total_score !== 16'd167) begin failures++; $display("FAIL title_keeps_total got=%0d exp=167", total_score); end
        tick(1);
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
        checks++; if ({total_score, level_num} !== {16'd0, 3'd0}) begin failures++; $display("FAIL restart_clear got=%0d/%0d exp=0/0", total_score, level_num); end
        tick(1);
        checks++; if (goal !== 16'd50) begin failures++; $display("FAIL restart_goal got=%0d exp=50", goal); end
    endtask

    task automatic test_reset_mid_play;
        score_in = 16'd9;
        tick(1);
        score_in = 16'd0;
        for (int k = 0; k < 2; k++) begin
            sof = 1'b1; tick(1); sof = 1'b0; tick(1);
        end
        checks++; if ({seconds_left, level_score} !== {7'd2, 16'd9}) begin failures++; $display("FAIL mid_state got=%0d/%0d exp=2/9", seconds_left, level_score); end
        resetN = 1'b0;
        #2;
        checks++; if (show_title !== 1'b1) begin failures++; $display("FAIL mid_rst_title got=%0b exp=1", show_title); end
        checks++; if ({timer_endedN, start_level} !== 2'b10) begin failures++; $display("FAIL mid_rst_flags got=%b exp=10", {timer_endedN, start_level}); end
        checks++; if ({seconds_left, level_score, total_score} !== 39'd0) begin failures++; $display("FAIL mid_rst_counts got=%0d/%0d/%0d exp=0/0/0", seconds_left, level_score, total_score); end
        tick(1);
        resetN = 1'b1;
    endtask

    task automatic test_saturation;
        resetN2 = 1'b0;
        tick(1);
        resetN2 = 1'b1;
        tick(1);
        enter2 = 1'b1;
        tick(1);
        enter2 = 1'b0;
        tick(1);
        score_in2 = 8'd200; tick(1);
        checks++; if (total_score2 !== 8'd200) begin failures++; $display("FAIL sat_first got=%0d exp=200", total_score2); end
        tick(1);
        checks++; if ({level_score2, total_score2} !== {8'd255, 8'd255}) begin failures++; $display("FAIL sat_clip got=%0d/%0d exp=255/255", level_score2, total_score2); end
        score_in2 = 8'd1; tick(1);
        score_in2 = 8'd0;
        checks++; if (total_score2 !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", total_score2); end
        resetN2 = 1'b0;
        #2;
        checks++; if ({show_title2, timer_endedN2} !== 2'b11) begin failures++; $display("FAIL sat_rst_flags got=%b exp=11", {show_title2, timer_endedN2}); end
        checks++; if ({level_score2, total_score2} !== 16'd0) begin failures++; $display("FAIL sat_rst_scores got=%0d/%0d exp=0/0", level_score2, total_score2); end
        tick(1);
        resetN2 = 1'b1;
    endtask

    initial begin
        tick(1);
        test_reset;
        test_start;
        test_countdown;
        test_level_win;
        test_game_over;
        test_reset_mid_play;
        test_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
